line_matrix_cfg: RTL
====================

Name: line_matrix_cfg

Overview:
- Configuration sequencer for a bank of line_mux instances forming a line matrix.
- Holds a shadow routing table with one input-select entry per output mux.
- On commit, sweeps the table onto the shared input_select/output_select bus, one entry per cycle.
- Software edits routes freely; the live matrix changes only on commit or clear.

Parameters:
NUM_INPUTS, 10, number of real input lines per mux
NUM_OUTPUTS, 10, number of output muxes on the shared config bus
SEL_W, $clog2(NUM_INPUTS+2), select width; 0 = const 0, 1 = const 1, 2+k = input_lines[k]
OUT_W, $clog2(NUM_OUTPUTS), output-address width

Ports:
clk  in  1  clock
rstn  in  1  reset; one clock, asynchronous active-low reset (rstn)
cfg_valid  in  1  table write request
cfg_ready  out  1  write accepted when valid&ready; equals ~busy
cfg_addr  in  OUT_W  output index to write
cfg_sel  in  SEL_W  select value for that output
commit  in  1  pulse: sweep shadow table to matrix
clear  in  1  pulse: zero shadow table, then sweep
rd_addr  in  OUT_W  shadow readback address
rd_sel  out  SEL_W  shadow[rd_addr], combinational; 0 if rd_addr out of range
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at sweep completion
err  out  1  sticky out-of-range write flag
err_clr  in  1  clears err
mux_output_select  out  OUT_W  config bus address to line_mux bank
mux_input_select  out  SEL_W  config bus data to line_mux bank

Behaviour:
- Reset (async, rstn=0):
  - shadow[*]=0; state IDLE; busy=0, done=0, err=0.
  - mux_output_select=0, mux_input_select=0, matching the line_mux reset value of 0.
  - cfg_ready=1 after reset release.
- Bus parking rule: a line_mux reloads every cycle its ID is addressed. The bus therefore never idles on arbitrary values. Outside a sweep it holds the last pair driven, or 0/0 after reset, so re-latching is harmless.
- All bus outputs, busy and done are registered.
- Writes:
  - Accepted on a clk edge with cfg_valid & cfg_ready.
  - In range when cfg_addr < NUM_OUTPUTS and cfg_sel <= NUM_INPUTS+1: shadow[cfg_addr] <= cfg_sel.
  - Out of range: the write is still accepted (handshake completes), data is dropped, err <= 1.
  - err_clr clears err. If err_clr and a new error occur in the same cycle, err is set.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP on clear or commit sampled at edge E; clear takes priority if both are asserted.
    - clear: every shadow entry is zeroed at E, and entry 0 is loaded as 0.
    - Write and commit in the same cycle: the write lands in the shadow at E and is included in the sweep.
  - SWEEP: idx counts 0..NUM_OUTPUTS-1.
    - At edge E+k, the bus loads mux_output_select=k, mux_input_select=shadow[k].
    - So pair k is on the bus in the cycle after E+k; mux k latches it at E+k+1.
  - SWEEP -> IDLE at edge E+NUM_OUTPUTS (mux NUM_OUTPUTS-1 latches there).
    - At that edge: busy<=0, done<=1 for one cycle.
    - The bus keeps holding pair NUM_OUTPUTS-1.
  - busy is 1 from edge E to edge E+NUM_OUTPUTS (exactly NUM_OUTPUTS cycles); cfg_ready is 0 during that span.
- Latency: commit to full matrix update = NUM_OUTPUTS+1 edges, counting E.
- commit/clear while busy: ignored, not queued, no error.
- cfg_valid held while busy: stalls, then is accepted on the first IDLE cycle.
- idx wrap: stops at NUM_OUTPUTS-1. No wrap, and no bus address >= NUM_OUTPUTS is ever driven.
- Reset mid-sweep: aborts immediately to reset values. The muxes share rstn, so the matrix returns to all-const-0 consistently.
- Shadow readback reflects writes from the edge after acceptance; it is unaffected by sweep progress.

Test Plan:
- Reset -> bus 0/0, busy=0, done=0, err=0, cfg_ready=1, rd_sel=0 for all addresses.
- Write addr3=5, addr7=11, then commit -> bus shows (0,0),(1,0),(2,0),(3,5),...,(7,11),(8,0),(9,0) on 10 consecutive cycles; busy high 10 cycles; done pulses once; bus holds (9,0) afterward.
- Write addr10=2 and, separately, addr4=12 (both out of range) -> err=1, shadow unchanged; err_clr -> err=0.
- Write addr2=9 in the same cycle as commit -> sweep drives (2,9); a commit pulsed mid-sweep produces no second sweep.
- Hold cfg_valid (addr1=3) during a sweep -> cfg_ready=0 until done; write accepted the cycle after busy falls; rd_sel(1)=3 next cycle.
- clear+commit together after table loaded -> all entries 0, sweep drives (k,0) for k=0..9; assert rstn=0 at idx=5 of a sweep -> bus 0/0, busy=0 asynchronously.

Source files
------------

// File: rtl/line_matrix_cfg.sv
// line_matrix_cfg: shadow routing table for a line_mux bank.
// Commit/clear sweeps the table onto the shared config bus.
module line_matrix_cfg #(
  parameter int NUM_INPUTS  = 10,
  parameter int NUM_OUTPUTS = 10,
  parameter int SEL_W       = $clog2(NUM_INPUTS + 2),
  parameter int OUT_W       = $clog2(NUM_OUTPUTS)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [OUT_W-1:0] cfg_addr,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic             commit,
  input  logic             clear,
  input  logic [OUT_W-1:0] rd_addr,
  output logic [SEL_W-1:0] rd_sel,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr,
  output logic [OUT_W-1:0] mux_output_select,
  output logic [SEL_W-1:0] mux_input_select
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state;
  state_t           state_nx;
  logic [SEL_W-1:0] shadow [NUM_OUTPUTS];
  logic             wr_acc;
  logic             wr_ok;
  logic             start;
  logic             last;
  logic [OUT_W-1:0] nxt_addr;
  logic [SEL_W-1:0] first_sel;

  assign cfg_ready = ~busy;
  assign wr_acc    = cfg_valid & cfg_ready;
  assign wr_ok     = wr_acc
                   && (int'(cfg_addr) < NUM_OUTPUTS)
                   && (int'(cfg_sel) <= NUM_INPUTS + 1);
  assign start     = (state == IDLE) & (commit | clear);
  assign last      = int'(mux_output_select) == NUM_OUTPUTS - 1;
  assign nxt_addr  = mux_output_select + 1'b1;

  assign rd_sel = (int'(rd_addr) < NUM_OUTPUTS)
                ? shadow[rd_addr] : '0;

  // Entry 0 goes out on the start edge, so bypass a same-cycle write.
  always_comb begin
    first_sel = shadow[0];
    unique case (1'b1)
      clear:                    first_sel = '0;
      wr_ok && cfg_addr == '0:  first_sel = cfg_sel;
      default:                  first_sel = shadow[0];
    endcase
  end

  // Next-state: start on commit/clear, stop after the last entry.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (commit | clear) state_nx = SWEEP;
      SWEEP:   if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Shadow table: clear wipes everything, else accepted in-range writes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) shadow[i] <= '0;
    end else if (start && clear) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) shadow[i] <= '0;
    end else if (wr_ok) begin
      shadow[cfg_addr] <= cfg_sel;
    end
  end

  // Sticky error; a new bad write wins over err_clr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  err <= 1'b0;
    else if (wr_acc && !wr_ok)  err <= 1'b1;
    else if (err_clr)           err <= 1'b0;
  end

  // Bus driver: park on last pair, walk addresses 0..N-1 during sweep.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mux_output_select <= '0;
      mux_input_select  <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mux_output_select <= '0;
        mux_input_select  <= first_sel;
        busy              <= 1'b1;
      end else if (state == SWEEP) begin
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          mux_output_select <= nxt_addr;
          mux_input_select  <= shadow[nxt_addr];
        end
      end
    end
  end

endmodule
